data_memory_pipelined: RTL and testbench
========================================

// Module: data_memory_pipelined
// PURPOSE
//   Byte-addressable, big-endian data RAM for the MEM stage with a valid/ready request port,
//   configurable read latency and tagged responses. Adds correct sub-word lane selection from
//   address[1:0], stall-aware response pipeline and misalignment detection. Sits between
//   execute outputs (alu_result, rt_data, load/store controls) and the memory_buffer register.
// PARAMETERS
//   DEPTH_BYTES   4096  RAM size in bytes; power of two, >= 4
//   READ_LATENCY  1     cycles from request acceptance to response; legal range 1..4
//   TAG_WIDTH     5     width of opaque tag carried request->response (e.g. rd address)
// PORTS
//   clk              in   1            clock, all state on rising edge
//   rst              in   1            asynchronous, active-high reset
//   stall            in   1            freezes response pipeline, deasserts req_ready
//   req_valid        in   1            request present
//   req_ready        out  1            request accepted when req_valid && req_ready
//   req_load         in   1            load request
//   req_store        in   1            store request
//   req_size         in   2            size_mode_e: 0 BYTE, 1 HALF, 2 WORD, 3 reserved
//   req_sign_extend  in   1            sign-extend sub-word loads
//   req_addr         in   32           byte address
//   req_wdata        in   32           store data, right-justified
//   req_tag          in   TAG_WIDTH    returned unchanged on resp_tag
//   resp_valid       out  1            response present (one per accepted request)
//   resp_rdata       out  32           load result; 0 for stores/suppressed accesses
//   resp_tag         out  TAG_WIDTH    tag of the responding request
//   resp_misalign    out  1            access was misaligned (see CONFIGURATION)
//   resp_illegal     out  1            req_load && req_store, or req_size == 3
// BEHAVIOUR
//   - req_ready = !stall (combinational). One request per cycle max.
//   - Address: addr_t = req_addr mod DEPTH_BYTES (wrap-around, no fault).
//   - Lanes, big-endian: byte offset k occupies wdata/rdata bits [31-8k -: 8] of the word.
//     BYTE writes mem[addr_t] <= wdata[7:0]; HALF writes addr_t, addr_t+1 <= wdata[15:8],[7:0];
//     WORD writes addr_t..addr_t+3 <= wdata[31:24]..[7:0].
//   - Stores commit on the accepting clock edge; a load accepted the following cycle sees them.
//   - Loads sample RAM on the accepting edge; data right-justified, upper bits zero, or
//     replicated MSB of the loaded byte/half when req_sign_extend. WORD ignores sign_extend.
//   - Illegal (load&&store, or size 3): no write, rdata 0, resp_illegal=1; still responds.
//   - Every accepted request produces exactly one response exactly READ_LATENCY unstalled
//     cycles later; order preserved. Request with neither load nor store: response, rdata 0.
//   - Stall: pipeline stages hold; resp_valid/resp_* held stable; no acceptance, no writes.
//   - Reset: all pipeline valid bits 0; resp_valid, resp_rdata, resp_tag, resp_misalign,
//     resp_illegal = 0. RAM contents not reset. In-flight responses discarded; a request
//     presented during reset is not accepted.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined: HALF with addr[0]=1 or WORD with addr[1:0]!=0 is
//     suppressed (no write, rdata 0) and responds with resp_misalign=1.
//   Not defined: low address bits forced to natural alignment (HALF clears bit 0, WORD
//     clears bits 1:0), access proceeds; resp_misalign tied 0.
// STRUCTURE
//   - dmem_pkg: size_mode_e enum, WIDTH=32, BYTE=8, lane-offset and sign-extend functions.
//   - Sub-module dmem_resp_pipe: READ_LATENCY-deep valid/data/tag/flag shift register
//     with stall hold and async reset; top holds RAM, decode and lane logic.
// TESTING
//   - WORD store 0xDEADBEEF @0x10, WORD load @0x10 -> rdata 0xDEADBEEF after READ_LATENCY.
//   - BYTE load @0x13 sign_ext=1 -> 0xFFFFFFEF; @0x10 sign_ext=0 -> 0x000000DE;
//     HALF @0x12 sign_ext=1 -> 0xFFFFBEEF.
//   - HALF store 0x1234 @0x12 then WORD load @0x10 -> 0xDEAD1234; BYTE store 0x5A @0x11
//     -> next WORD load 0xDE5A1234.
//   - READ_LATENCY=3, back-to-back loads tags 1,2,3 with 2-cycle stall mid-stream ->
//     responses in order, held during stall, each exactly 3 unstalled cycles after accept.
//   - WORD load @0x12: with DMEM_MISALIGN_TRAP_EN -> misalign=1, rdata 0; without -> reads @0x10.
//   - rst asserted with 2 loads in flight -> resp_valid 0 immediately, no stale response
//     after release; store @DEPTH_BYTES+4 aliases @0x4; load&&store -> resp_illegal=1, RAM unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined big-endian data memory.
package dmem_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned BYTE  = 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_mode_e;

    // Distance, in byte lanes, from the access's least-significant lane to bit 0 of the word.
    // Big-endian: byte offset 0 is the most significant lane.
    function automatic logic [1:0] lane_pos(input size_mode_e size, input logic [1:0] offset);
        logic [1:0] pos;
        case (size)
            SIZE_BYTE: pos = 2'd3 - offset;
            SIZE_HALF: pos = 2'd2 - offset;
            default:   pos = 2'd0;
        endcase
        return pos;
    endfunction

    function automatic logic [3:0] lane_mask(input size_mode_e size);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001;
            SIZE_HALF: mask = 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [WIDTH-1:0] extend(input size_mode_e size, input logic sign_en,
                                                input logic [WIDTH-1:0] raw);
        logic [WIDTH-1:0] res;
        case (size)
            SIZE_BYTE: res = {{24{sign_en & raw[7]}}, raw[7:0]};
            SIZE_HALF: res = {{16{sign_en & raw[15]}}, raw[15:0]};
            default:   res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Response delay line: LATENCY stages of valid + payload, frozen while stall is high,
// cleared by asynchronous reset.
module dmem_resp_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0]             valid_q, valid_d, shift_valid;
    logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d, shift_data;

    generate
        if (LATENCY == 1) begin : g_single
            assign shift_valid   = in_valid;
            assign shift_data[0] = in_data;
        end else begin : g_multi
            assign shift_valid = {valid_q[LATENCY-2:0], in_valid};
            assign shift_data  = {data_q[LATENCY-2:0], in_data};
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d = shift_valid;
            data_d  = shift_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/data_memory_pipelined.sv
// Byte-addressable big-endian MEM-stage RAM with tagged, fixed-latency responses.
// Define DMEM_MISALIGN_TRAP_EN to suppress and flag misaligned HALF/WORD accesses.
module data_memory_pipelined
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES  = 4096,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TAG_WIDTH    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_load,
    input  logic                 req_store,
    input  logic [1:0]           req_size,
    input  logic                 req_sign_extend,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic [TAG_WIDTH-1:0] resp_tag,
    output logic                 resp_misalign,
    output logic                 resp_illegal
);

    localparam int unsigned NWORDS = DEPTH_BYTES / 4;
    localparam int unsigned WAW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned PAY_W  = WIDTH + TAG_WIDTH + 2;

    logic [WIDTH-1:0] mem [NWORDS];

    size_mode_e       size;
    logic [WAW-1:0]   word_idx;
    logic [1:0]       offset;
    logic [1:0]       pos;
    logic [4:0]       shamt;
    logic             accept, illegal, misalign, suppress, wr_en;
    logic [3:0]       byte_en;
    logic [WIDTH-1:0] wr_word, rd_raw, ld_data, rdata;
    logic [PAY_W-1:0] pay_in, pay_out;
    logic             unused_addr_bits;

    assign size             = size_mode_e'(req_size);
    assign word_idx         = req_addr[WAW+1:2];
    assign unused_addr_bits = ^req_addr[31:WAW+2];
    assign req_ready        = !stall;

    always_comb begin
        accept  = req_valid && !stall && !rst;
        illegal = (req_load && req_store) || (size == SIZE_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
        offset   = req_addr[1:0];
        misalign = ((size == SIZE_HALF) && req_addr[0]) ||
                   ((size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
        // Misaligned HALF/WORD silently snap down to their natural boundary.
        offset   = req_addr[1:0];
        misalign = 1'b0;
        if (size == SIZE_HALF) offset = {req_addr[1], 1'b0};
        if (size == SIZE_WORD) offset = 2'b00;
`endif
        suppress = illegal || misalign;
        wr_en    = accept && req_store && !suppress;

        pos     = lane_pos(size, offset);
        shamt   = {pos, 3'b000};
        byte_en = lane_mask(size) << pos;
        wr_word = req_wdata << shamt;
        rd_raw  = mem[word_idx] >> shamt;
        ld_data = extend(size, req_sign_extend, rd_raw);
        rdata   = (req_load && !suppress) ? ld_data : '0;
        pay_in  = accept ? {rdata, req_tag, misalign, illegal} : '0;
    end

    // RAM is deliberately left out of reset; byte_en bit 3 is byte offset 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (byte_en[3]) mem[word_idx][31:24] <= wr_word[31:24];
            if (byte_en[2]) mem[word_idx][23:16] <= wr_word[23:16];
            if (byte_en[1]) mem[word_idx][15:8]  <= wr_word[15:8];
            if (byte_en[0]) mem[word_idx][7:0]   <= wr_word[7:0];
        end
    end

    dmem_resp_pipe #(
        .LATENCY (READ_LATENCY),
        .DATA_W  (PAY_W)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .in_valid  (accept),
        .in_data   (pay_in),
        .out_valid (resp_valid),
        .out_data  (pay_out)
    );

    assign {resp_rdata, resp_tag, resp_misalign, resp_illegal} = pay_out;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench for data_memory_pipelined at READ_LATENCY=3; works with or without
// DMEM_MISALIGN_TRAP_EN.
module tb_data_memory_pipelined;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned RL    = 3;
    localparam int unsigned TW    = 5;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif
    // Word at 0x10 after the misaligned HALF store of 0xABCD @0x13.
    localparam logic [31:0] EXP10 = TRAP ? 32'hDE5A1234 : 32'hDE5AABCD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0, req_sign_extend = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic [31:0]   req_addr = '0, req_wdata = '0;
    logic [TW-1:0] req_tag = '0;
    logic          req_ready, resp_valid, resp_misalign, resp_illegal;
    logic [31:0]   resp_rdata;
    logic [TW-1:0] resp_tag;

    always #5 clk = ~clk;

    data_memory_pipelined #(
        .DEPTH_BYTES  (DEPTH),
        .READ_LATENCY (RL),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk (clk), .rst (rst), .stall (stall),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_load (req_load), .req_store (req_store), .req_size (req_size),
        .req_sign_extend (req_sign_extend), .req_addr (req_addr),
        .req_wdata (req_wdata), .req_tag (req_tag),
        .resp_valid (resp_valid), .resp_rdata (resp_rdata), .resp_tag (resp_tag),
        .resp_misalign (resp_misalign), .resp_illegal (resp_illegal)
    );

    typedef struct {
        logic [31:0]   rdata;
        logic [TW-1:0] tag;
        logic          mis;
        logic          ill;
        int unsigned   due;
    } exp_t;

    exp_t        q[$];
    exp_t        pend;
    exp_t        last_exp;
    logic        last_valid = 1'b0;
    bit          stall_last = 1'b0;
    int unsigned adv = 0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Counts unstalled edges and records accepted requests with their due edge.
    always @(posedge clk) begin
        stall_last = stall;
        if (!rst && !stall) begin
            adv++;
            if (req_valid) begin
                pend.due = adv + RL - 1;
                q.push_back(pend);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("reset_valid", {31'b0, resp_valid}, 32'd0);
            last_valid = 1'b0;
        end else if (stall_last) begin
            check("hold_valid", {31'b0, resp_valid}, {31'b0, last_valid});
            if (last_valid && resp_valid) begin
                check("hold_rdata", resp_rdata, last_exp.rdata);
                check("hold_tag", {27'b0, resp_tag}, {27'b0, last_exp.tag});
            end
        end else begin
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    last_exp = q.pop_front();
                    check("rdata", resp_rdata, last_exp.rdata);
                    check("tag", {27'b0, resp_tag}, {27'b0, last_exp.tag});
                    check("misalign", {31'b0, resp_misalign}, {31'b0, last_exp.mis});
                    check("illegal", {31'b0, resp_illegal}, {31'b0, last_exp.ill});
                    check("latency", adv, last_exp.due);
                end
            end
            last_valid = resp_valid;
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [TW-1:0] tag,
                         input logic [31:0] er, input logic em, input logic ei);
        bit done;
        pend            = '{rdata: er, tag: tag, mis: em, ill: ei, due: 0};
        req_valid       = 1'b1;
        req_load        = ld;
        req_store       = st;
        req_size        = sz;
        req_sign_extend = sx;
        req_addr        = addr;
        req_wdata       = wd;
        req_tag         = tag;
        done            = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            if (!stall && !rst) done = 1'b1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_tag", {27'b0, resp_tag}, 32'd0);
        check("rst_misalign", {31'b0, resp_misalign}, 32'd0);
        check("rst_illegal", {31'b0, resp_illegal}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        //     ld    st    size  sx    addr          wdata          tag    expect        mis   ill
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 5'd1,  32'h0,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd2,  32'hDEADBEEF, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        5'd3,  32'hFFFFFFEF, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h10,       32'h0,        5'd4,  32'h000000DE, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h12,       32'h0,        5'd5,  32'hFFFFBEEF, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h12,       32'h1234,     5'd6,  32'h0,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd7,  32'hDEAD1234, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h11,       32'h5A,       5'd8,  32'h0,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd9,  32'hDE5A1234, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h10,       32'h0,        5'd10, 32'hFFFFDE5A, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h11,       32'h0,        5'd11, 32'h0000005A, 1'b0, 1'b0);
        // Misaligned accesses: trapped, or snapped to the natural boundary.
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h12,       32'h0,        5'd12, TRAP ? 32'h0 : 32'hDE5A1234, TRAP, 1'b0);
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h13,       32'hABCD,     5'd13, 32'h0,        TRAP, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd14, EXP10,        1'b0, 1'b0);
        // Address wrap, illegal encodings, no-op request.
        issue(1'b0, 1'b1, 2'd2, 1'b0, DEPTH + 32'h4, 32'hCAFEF00D, 5'd15, 32'h0,       1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h4,        32'h0,        5'd16, 32'hCAFEF00D, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h10,       32'hFFFFFFFF, 5'd17, 32'h0,        1'b0, 1'b1);
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        5'd18, 32'h0,        1'b0, 1'b1);
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd19, 32'h0,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd20, EXP10,        1'b0, 1'b0);

        // Back-to-back loads with a two-cycle stall while the first response is presented.
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd1,  EXP10,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h4,        32'h0,        5'd2,  32'h000000CA, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h6,        32'h0,        5'd3,  32'hFFFFF00D, 1'b0, 1'b0);
        fork
            issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h4,    32'h0,        5'd4,  32'hCAFEF00D, 1'b0, 1'b0);
            begin
                stall = 1'b1;
                repeat (2) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        repeat (RL + 2) @(posedge clk);
        #1;

        // Reset with loads in flight; a store presented during reset must not land.
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd5,  EXP10,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd6,  EXP10,        1'b0, 1'b0);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd7,  EXP10,        1'b0, 1'b0);
        rst = 1'b1;
        q.delete();
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'd2;
        req_addr = 32'h10; req_wdata = 32'h11111111;
        #1;
        check("rst_async_valid", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (RL + 2) @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        5'd8,  EXP10,        1'b0, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
